display_scheduler: RTL

Sequences the board's three-way hex display multiplexer, driving its 2-bit select so the 32-bit operand/result buses (A, B, C) are shown in turn on HEX0–HEX7. Two modes: auto-rotation on a programmable dwell timer, or manual stepping from a pushbutton. Buses can be masked out of the rotation. Sits between the board keys/switches and the display multiplexer in the ALU checker top level.

---
 rtl/display_sched_pkg.sv | 51 +++++
 rtl/key_debounce.sv | 79 +++++++
 rtl/display_scheduler.sv | 96 +++++++++
 3 files changed

// File: rtl/display_sched_pkg.sv
// Shared types and encodings for the hex display scheduler.
// Used by display_scheduler and key_debounce.
package display_sched_pkg;

  typedef enum logic [1:0] {
    SHOW_A = 2'd0,
    SHOW_B = 2'd1,
    SHOW_C = 2'd2
  } state_e;

  localparam logic [1:0] SEL_A = 2'b01;
  localparam logic [1:0] SEL_B = 2'b10;
  localparam logic [1:0] SEL_C = 2'b00;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;

  function automatic state_e succ(input state_e s);
    case (s)
      SHOW_A:  return SHOW_B;
      SHOW_B:  return SHOW_C;
      default: return SHOW_A;
    endcase
  endfunction

  function automatic logic bus_en(input state_e s, input logic [2:0] mask);
    case (s)
      SHOW_A:  return mask[0];
      SHOW_B:  return mask[1];
      default: return mask[2];
    endcase
  endfunction

  function automatic logic [1:0] sel_of(input state_e s);
    case (s)
      SHOW_A:  return SEL_A;
      SHOW_B:  return SEL_B;
      default: return SEL_C;
    endcase
  endfunction

  function automatic logic [1:0] idx_of(input state_e s);
    case (s)
      SHOW_A:  return IDX_A;
      SHOW_B:  return IDX_B;
      default: return IDX_C;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, optional debounce, registered press pulse.
// Debounce stage is compiled in with DISPLAY_SCHEDULER_DEBOUNCE_EN.
module key_debounce
  import display_sched_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic press_q;
  logic level_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef DISPLAY_SCHEDULER_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            db_lvl_q;
  logic            db_lvl_d;

  // Count consecutive samples that differ from the held level; any match restarts.
  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_lvl_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b1;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  assign level_c = db_lvl_q;
`else
  assign level_c = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      prev_q  <= level_c;
      press_q <= !level_c && prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/display_scheduler.sv
// Rotates the hex display mux select over buses A/B/C by dwell timer or key press.
// Optional key debounce via DISPLAY_SCHEDULER_DEBOUNCE_EN.
module display_scheduler
  import display_sched_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES    = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       auto_en,
  input  logic       key_next,
  input  logic [2:0] en_mask,
  output logic [1:0] sel,
  output logic [1:0] cur_idx,
  output logic       tick
);

  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       sel_q;
  logic [1:0]       sel_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic             tick_q;
  logic             tick_d;
  logic             press;
  logic             any_en;
  logic             dwell_exp;
  logic             forced;
  logic             adv_req;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_i  (key_next),
    .press_o(press)
  );

  // Next state: all advance sources merge into one request; skip masked buses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    any_en    = |en_mask;
    dwell_exp = auto_en && (cnt_q == CNT_LAST);
    forced    = any_en && !bus_en(state_q, en_mask);
    adv_req   = any_en && (dwell_exp || press || forced);

    if (adv_req) begin
      if (bus_en(succ(state_q), en_mask)) begin
        state_d = succ(state_q);
      end else if (bus_en(succ(succ(state_q)), en_mask)) begin
        state_d = succ(succ(state_q));
      end
    end

    // Expiry clears even when fully masked so the counter never saturates.
    if (!auto_en || adv_req || dwell_exp) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    sel_d  = sel_of(state_d);
    idx_d  = idx_of(state_d);
    tick_d = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SHOW_A;
      cnt_q   <= '0;
      sel_q   <= SEL_A;
      idx_q   <= IDX_A;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
    end
  end

  assign sel     = sel_q;
  assign cur_idx = idx_q;
  assign tick    = tick_q;

endmodule
